// File: rtl/btb_predictor_pkg.sv
// Shared definitions for the branch target buffer: counter encodings, allocation
// values and entry field widths. Counter width depends on BTB_2BIT_CTR_EN.
package btb_predictor_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr2_e;

  typedef enum logic [1:0] {
    CTR_HOLD,
    CTR_LOAD,
    CTR_INC,
    CTR_DEC
  } ctr_op_e;

`ifdef BTB_2BIT_CTR_EN
  localparam int              CTR_W    = 2;
  localparam logic [CTR_W-1:0] CTR_RST  = WNT;
  localparam logic [CTR_W-1:0] CTR_INIT = WT;
  localparam logic [CTR_W-1:0] CTR_JMP  = ST;
`else
  // Single-bit mode: the bit is simply the last observed direction.
  localparam int              CTR_W    = 1;
  localparam logic [CTR_W-1:0] CTR_RST  = 1'b0;
  localparam logic [CTR_W-1:0] CTR_INIT = 1'b1;
  localparam logic [CTR_W-1:0] CTR_JMP  = 1'b1;
`endif

  function automatic int idx_w(input int entries);
    return $clog2(entries);
  endfunction

  function automatic int tag_w(input int addr_w, input int entries);
    return addr_w - $clog2(entries) - 2;
  endfunction

endpackage

// File: rtl/btb_satctr.sv
// Per-entry direction counter: hold, load, saturating increment or decrement.
module btb_satctr
  import btb_predictor_pkg::*;
#(
  parameter int             W       = CTR_W,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  ctr_op_e      i_op,
  input  logic [W-1:0] i_load,
  output logic [W-1:0] o_ctr
);

  logic [W-1:0] r_ctr;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of process order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctr <= RST_VAL;
    end else begin
      case (i_op)
        CTR_LOAD: r_ctr <= i_load;
        CTR_INC:  if (r_ctr != '1) r_ctr <= r_ctr + W'(1);
        CTR_DEC:  if (r_ctr != '0) r_ctr <= r_ctr - W'(1);
        default:  r_ctr <= r_ctr;
      endcase
    end
  end

  assign o_ctr = r_ctr;

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with fetch lookup, execute-stage update and
// misprediction detection. Define BTB_2BIT_CTR_EN for 2-bit saturating counters.
module btb_predictor
  import btb_predictor_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pcF,
  output logic              predhitF,
  output logic              predtakenF,
  output logic [ADDR_W-1:0] predpcF,
  input  logic              flushall,
  input  logic              updvalidE,
  input  logic [ADDR_W-1:0] updpcE,
  input  logic [ADDR_W-1:0] updtargetE,
  input  logic              updtakenE,
  input  logic              updisjE,
  input  logic              predtakenE,
  input  logic [ADDR_W-1:0] predpcE,
  output logic              mispredictE,
  output logic [31:0]       cnt_upd,
  output logic [31:0]       cnt_mis
);

  localparam int IDXW = idx_w(ENTRIES);
  localparam int TAGW = tag_w(ADDR_W, ENTRIES);

  logic [ENTRIES-1:0] r_valid;
  logic [ENTRIES-1:0] r_isj;
  logic [TAGW-1:0]    r_tag    [ENTRIES];
  logic [ADDR_W-1:0]  r_target [ENTRIES];
  logic [CTR_W-1:0]   w_ctr    [ENTRIES];
  logic               r_run;
  logic [31:0]        r_cnt_upd;
  logic [31:0]        r_cnt_mis;

  logic [IDXW-1:0]    w_f_idx;
  logic [TAGW-1:0]    w_f_tag;
  logic [IDXW-1:0]    w_u_idx;
  logic [TAGW-1:0]    w_u_tag;
  logic               w_u_hit;
  logic               w_upd_go;
  logic               w_wr_en;
  ctr_op_e            w_ctr_op;
  logic [CTR_W-1:0]   w_ctr_load;
  logic               w_unused;

  assign w_f_idx  = pcF[IDXW+1:2];
  assign w_f_tag  = pcF[ADDR_W-1:IDXW+2];
  assign w_u_idx  = updpcE[IDXW+1:2];
  assign w_u_tag  = updpcE[ADDR_W-1:IDXW+2];
  assign w_unused = ^{updpcE[1:0]};

  // Lookup reads only registered state, so a same-cycle update is invisible here.
  assign predhitF    = reset & r_valid[w_f_idx] & (r_tag[w_f_idx] == w_f_tag);
  assign predtakenF  = predhitF & (r_isj[w_f_idx] | w_ctr[w_f_idx][CTR_W-1]);
  assign predpcF     = predtakenF ? r_target[w_f_idx] : pcF + ADDR_W'(4);

  assign mispredictE = updvalidE & ((predtakenE != updtakenE) |
                                    (updtakenE & (predpcE != updtargetE)));

  // r_run blocks any update sampled on the reset-release edge.
  assign w_u_hit  = r_valid[w_u_idx] & (r_tag[w_u_idx] == w_u_tag);
  assign w_upd_go = r_run & updvalidE & ~flushall;
  assign w_wr_en  = w_upd_go & updtakenE;

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_ctr_op   = CTR_HOLD;
    w_ctr_load = CTR_INIT;
`ifdef BTB_2BIT_CTR_EN
    if (w_wr_en) begin
      if (updisjE) begin
        w_ctr_op   = CTR_LOAD;
        w_ctr_load = CTR_JMP;
      end else if (w_u_hit) begin
        w_ctr_op   = CTR_INC;
      end else begin
        w_ctr_op   = CTR_LOAD;
        w_ctr_load = CTR_INIT;
      end
    end else if (w_upd_go && w_u_hit) begin
      w_ctr_op = CTR_DEC;
    end
`else
    if (w_wr_en) begin
      w_ctr_op   = CTR_LOAD;
      w_ctr_load = updisjE ? CTR_JMP : CTR_INIT;
    end else if (w_upd_go && w_u_hit) begin
      w_ctr_op   = CTR_LOAD;
      w_ctr_load = '0;
    end
`endif
  end

  for (genvar g = 0; g < ENTRIES; g++) begin : g_ctr
    ctr_op_e w_op_g;
    assign w_op_g = (w_u_idx == IDXW'(g)) ? w_ctr_op : CTR_HOLD;

    btb_satctr #(
      .W       (CTR_W),
      .RST_VAL (CTR_RST)
    ) u_ctr (
      .clk    (clk),
      .rst_n  (reset),
      .i_op   (w_op_g),
      .i_load (w_ctr_load),
      .o_ctr  (w_ctr[g])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= '0;
      r_run   <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (flushall) begin
        r_valid <= '0;
      end else if (w_wr_en) begin
        r_valid[w_u_idx] <= 1'b1;
      end
    end
  end

  // NOTE: tag/target/isj storage has no reset; valid bits gate every read,
  // so leaving the arrays unreset lets them map onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_tag[w_u_idx]    <= w_u_tag;
      r_target[w_u_idx] <= updtargetE;
      r_isj[w_u_idx]    <= updisjE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt_upd <= '0;
      r_cnt_mis <= '0;
    end else if (r_run) begin
      if (updvalidE && (r_cnt_upd != '1)) r_cnt_upd <= r_cnt_upd + 32'd1;
      if (mispredictE && (r_cnt_mis != '1)) r_cnt_mis <= r_cnt_mis + 32'd1;
    end
  end

  assign cnt_upd = r_cnt_upd;
  assign cnt_mis = r_cnt_mis;

endmodule

// File: doc/btb_predictor.md
BTB_PREDICTOR -- requirements
Module: btb_predictor

Interface
REQ-001 Parameter ENTRIES, default 16, number of BTB entries; power of two, 2 to 256.
REQ-002 Parameter ADDR_W, default 32, PC/target width.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 pcF  input  ADDR_W  fetch-stage PC to look up.
REQ-006 predhitF  output  1  pcF matches a valid entry.
REQ-007 predtakenF  output  1  predict taken for pcF.
REQ-008 predpcF  output  ADDR_W  predicted next PC.
REQ-009 flushall  input  1  invalidate every entry.
REQ-010 updvalidE  input  1  a branch or jump resolved in execute this cycle.
REQ-011 updpcE, updtargetE  input  ADDR_W each  resolved instruction PC and actual target.
REQ-012 updtakenE, updisjE  input  1 each  actual outcome; instruction is an unconditional jump.
REQ-013 predtakenE, predpcE  input  1 / ADDR_W  prediction carried down the pipe with the instruction.
REQ-014 mispredictE  output  1  redirect/flush request to the PC mux.
REQ-015 cnt_upd, cnt_mis  output  32 each  resolved-branch and misprediction counts.

Function
REQ-016 The index SHALL be pc[IDXW+1:2] and the tag pc[ADDR_W-1:IDXW+2], where IDXW=log2(ENTRIES).
REQ-017 Each entry SHALL hold: valid, tag, target[ADDR_W], isj, and ctr (2-bit).
REQ-018 Lookup SHALL be combinational from registered table state, with zero-cycle latency.
REQ-019 predhitF SHALL be valid & (tag==pcF tag); predtakenF = predhitF & (isj | ctr[1]).
REQ-020 predpcF SHALL be the entry target when predtakenF=1; otherwise pcF+4 (mod 2^ADDR_W).
REQ-021 On updvalidE & updtakenE, the entry at updpcE's index SHALL be written with valid=1, the tag, updtargetE and updisjE.
REQ-022 In that write, ctr SHALL become 11 if updisjE; saturating increment if the tag hit; 10 (weakly taken) on a new allocation or replacement.
REQ-023 On updvalidE & !updtakenE with a tag hit, ctr SHALL saturate-decrement; a tag miss SHALL leave the table unchanged (no allocation on not-taken).
REQ-024 mispredictE SHALL be combinational: updvalidE & ((predtakenE!=updtakenE) | (updtakenE & predpcE!=updtargetE)).
REQ-025 cnt_upd SHALL increment on each updvalidE; cnt_mis on each mispredictE=1; both saturate at 0xFFFFFFFF.
REQ-026 When lookup and update hit the same index in one cycle, lookup SHALL return the pre-update contents.
REQ-027 flushall SHALL clear all valid bits at the next edge and take priority over a same-cycle update; ctr, targets and counters are unaffected.

Reset
REQ-028 While reset=0, all valid bits, ctr fields (to 01), cnt_upd and cnt_mis SHALL clear immediately.
REQ-029 During reset, predhitF=0, predtakenF=0, predpcF=pcF+4; mispredictE still follows REQ-024.
REQ-030 Target/tag storage SHALL need no reset; an update coincident with reset release-edge is ignored.

Configuration
REQ-031 With macro BTB_2BIT_CTR_EN defined, counters SHALL behave per REQ-022/023.
REQ-032 Without BTB_2BIT_CTR_EN, ctr SHALL be 1 bit: set to updtakenE on any hit or allocation (1 for jumps), and predtakenF = predhitF & (isj | ctr).

Structure
REQ-033 A shared package SHALL hold the counter encodings (SNT=00, WNT=01, WT=10, ST=11), the allocation init value, and the entry field-width constants.
REQ-034 The saturating up/down counter SHALL be one sub-module, btb_satctr, instantiated per entry.

Verification
REQ-035 Reset, then pcF=0x40 -> predhitF=0, predtakenF=0, predpcF=0x44.
REQ-036 Update pc=0x40, taken, target=0x100, predtakenE=0 -> mispredictE=1, cnt_mis=1; next cycle pcF=0x40 -> hit, taken, predpcF=0x100.
REQ-037 Two not-taken updates at 0x40 after REQ-036 -> ctr 10->01->00, predtakenF=0; a jump update at 0x40 -> ctr=11, taken.
REQ-038 Alias: pc=0x440 taken (target 0x200) replaces 0x40 (same index 0, tag 0x11) -> pcF=0x40 misses, pcF=0x440 hits with 0x200.
REQ-039 flushall with a simultaneous update at 0x80 -> all lookups miss next cycle; the 0x80 entry is not written.
REQ-040 Force cnt_upd to 0xFFFFFFFF via 2^32 updates or a backdoor preset, apply one more update -> remains 0xFFFFFFFF.
